// File: rtl/addsub_result_stage.sv
// Result stage behind the 16-bit add/subtract unit.
// Registers each accepted operation together with its NZCV status and borrow
// into a 2-entry FIFO. Overflowed results can be clamped to the signed
// limits. A sticky, saturating counter tracks how many overflowed
// operations were accepted.
module addsub_result_stage #(
  parameter int WIDTH  = 16,
  parameter bit SAT_EN = 1'b1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  input  logic             in_ovf,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_flags,
  output logic             out_borrow,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             clr_cnt
);

  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] mem_data   [2];
  logic [3:0]       mem_flags  [2];
  logic             mem_borrow [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             borrow;

  // ready is purely registered occupancy, so out_ready never reaches in_ready
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data   = mem_data[rd_ptr];
  assign out_flags  = mem_flags[rd_ptr];
  assign out_borrow = mem_borrow[rd_ptr];

  // Compute the stored result and status; C and V stay raw even when clamped.
  always_comb begin
    result = in_sum;
    if (SAT_EN && in_ovf) begin
      // Wrapped-negative sum means the true result overflowed upward.
      result = in_sum[WIDTH-1] ? SAT_POS : SAT_NEG;
    end
    flags  = {result[WIDTH-1], (result == '0), in_cout, in_ovf};
    borrow = in_sub & ~in_cout;
  end

  // Entry storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_data[i]   <= '0;
        mem_flags[i]  <= '0;
        mem_borrow[i] <= 1'b0;
      end
    end else if (push) begin
      mem_data[wr_ptr]   <= result;
      mem_flags[wr_ptr]  <= flags;
      mem_borrow[wr_ptr] <= borrow;
    end
  end

  // Pointer and occupancy bookkeeping; 1-bit pointers wrap 1->0 naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow counter; a clear coinciding with an overflow push counts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (clr_cnt) begin
      ovf_cnt <= (push && in_ovf) ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
    end else if (push && in_ovf && (ovf_cnt != CNT_MAX)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_addsub_result_stage.sv
// Self-checking bench for addsub_result_stage: per-scenario tasks with inline
// checks, plus a scoreboard that predicts every delivered entry.
module tb_addsub_result_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_sum;
  logic        in_cout;
  logic        in_ovf;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_flags;
  logic        out_borrow;
  logic [7:0]  ovf_cnt;
  logic        clr_cnt;

  logic        ns_in_ready;
  logic        ns_out_valid;
  logic [15:0] ns_out_data;
  logic [3:0]  ns_out_flags;
  logic        ns_out_borrow;
  logic [7:0]  ns_ovf_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  logic [20:0] sb_q[$];
  logic [7:0]  exp_cnt;

  addsub_result_stage #(.WIDTH(16), .SAT_EN(1'b1), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_cout(in_cout), .in_ovf(in_ovf), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags), .out_borrow(out_borrow), .ovf_cnt(ovf_cnt),
    .clr_cnt(clr_cnt)
  );

  addsub_result_stage #(.WIDTH(16), .SAT_EN(1'b0), .CNT_W(8)) u_dut_nosat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ns_in_ready),
    .in_sum(in_sum), .in_cout(in_cout), .in_ovf(in_ovf), .in_sub(in_sub),
    .out_valid(ns_out_valid), .out_ready(out_ready), .out_data(ns_out_data),
    .out_flags(ns_out_flags), .out_borrow(ns_out_borrow), .ovf_cnt(ns_ovf_cnt),
    .clr_cnt(clr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] model(input logic [15:0] s, input logic c,
                                        input logic o, input logic sb);
    logic [15:0] r;
    r = o ? (s[15] ? 16'h7FFF : 16'h8000) : s;
    return {r, r[15], (r == 16'h0000), c, o, sb & ~c};
  endfunction

  // Scoreboard: sample on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_cnt = 8'd0;
    end else begin
      if (out_valid && out_ready) begin
        n_checks++;
        n_pops++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_output: got data=%h flags=%b borrow=%b, expected no output",
                   out_data, out_flags, out_borrow);
        end else begin
          logic [20:0] e;
          e = sb_q.pop_front();
          if ({out_data, out_flags, out_borrow} !== e) begin
            n_fail++;
            $display("FAIL sb_entry: got data=%h flags=%b borrow=%b, expected data=%h flags=%b borrow=%b",
                     out_data, out_flags, out_borrow, e[20:5], e[4:1], e[0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(in_sum, in_cout, in_ovf, in_sub));
        if (clr_cnt)                        exp_cnt = in_ovf ? 8'd1 : 8'd0;
        else if (in_ovf && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      end else if (clr_cnt) begin
        exp_cnt = 8'd0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [15:0] s, input logic c, input logic o, input logic sb);
    in_valid = 1'b1;
    in_sum   = s;
    in_cout  = c;
    in_ovf   = o;
    in_sub   = sb;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, in_ready, out_data, out_flags, out_borrow, ovf_cnt} !== {1'b0, 1'b1, 16'h0, 4'h0, 1'b0, 8'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b ready=%b data=%h flags=%b borrow=%b cnt=%0d, expected 0 1 0000 0000 0 0",
               out_valid, in_ready, out_data, out_flags, out_borrow, ovf_cnt);
    end
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_add();
    out_ready = 1'b1;
    set_op(16'h1235, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_data, out_flags, out_borrow, ovf_cnt} !== {1'b1, 16'h1235, 4'b0000, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL basic_add: got valid=%b data=%h flags=%b borrow=%b cnt=%0d, expected 1 1235 0000 0 0",
               out_valid, out_data, out_flags, out_borrow, ovf_cnt);
    end
    step();
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    set_op(16'h8000, 1'b0, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_data, out_flags, ovf_cnt} !== {16'h7FFF, 4'b0001, 8'd1}) begin
      n_fail++;
      $display("FAIL sat_on: got data=%h flags=%b cnt=%0d, expected 7fff 0001 1",
               out_data, out_flags, ovf_cnt);
    end
    n_checks++;
    if ({ns_out_valid, ns_out_data, ns_out_flags} !== {1'b1, 16'h8000, 4'b1001}) begin
      n_fail++;
      $display("FAIL sat_off: got valid=%b data=%h flags=%b, expected 1 8000 1001",
               ns_out_valid, ns_out_data, ns_out_flags);
    end
    step();
  endtask

  task automatic test_subtract();
    out_ready = 1'b1;
    set_op(16'h0000, 1'b1, 1'b0, 1'b1);
    step();
    n_checks++;
    if ({out_data, out_flags, out_borrow} !== {16'h0000, 4'b0110, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_equal: got data=%h flags=%b borrow=%b, expected 0000 0110 0",
               out_data, out_flags, out_borrow);
    end
    set_op(16'hFFFE, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_data, out_flags, out_borrow} !== {16'hFFFE, 4'b1000, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_borrow: got data=%h flags=%b borrow=%b, expected fffe 1000 1",
               out_data, out_flags, out_borrow);
    end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    set_op(16'h00A1, 1'b0, 1'b0, 1'b0);
    step();
    set_op(16'h00B2, 1'b0, 1'b0, 1'b0);
    step();
    set_op(16'h00C3, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b01) begin
      n_fail++;
      $display("FAIL full_ready: got ready=%b valid=%b, expected 0 1", in_ready, out_valid);
    end
    repeat (3) step();
    n_checks++;
    if ({in_ready, out_data} !== {1'b0, 16'h00A1}) begin
      n_fail++;
      $display("FAIL hold_head: got ready=%b data=%h, expected 0 00a1", in_ready, out_data);
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if ({in_ready, out_valid, out_data} !== {1'b1, 1'b1, 16'h00B2}) begin
      n_fail++;
      $display("FAIL first_pop: got ready=%b valid=%b data=%h, expected 1 1 00b2",
               in_ready, out_valid, out_data);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, 16'h00C3}) begin
      n_fail++;
      $display("FAIL late_accept: got valid=%b data=%h, expected 1 00c3", out_valid, out_data);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: got valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_counter();
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      set_op(16'($urandom), 1'($urandom), 1'b1, 1'($urandom));
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (ovf_cnt !== 8'd255 || exp_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL cnt_saturate: got %0d (model %0d), expected 255", ovf_cnt, exp_cnt);
    end
    set_op(16'h8000, 1'b0, 1'b1, 1'b0);
    clr_cnt = 1'b1;
    step();
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    n_checks++;
    if (ovf_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL cnt_clr_with_ovf: got %0d, expected 1", ovf_cnt);
    end
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    n_checks++;
    if (ovf_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL cnt_clr: got %0d, expected 0", ovf_cnt);
    end
    step();
  endtask

  task automatic test_reset_mid_stream();
    int base;
    out_ready = 1'b0;
    set_op(16'h4000, 1'b0, 1'b1, 1'b0);
    step();
    set_op(16'h0055, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, ovf_cnt, out_data, out_flags} !== {1'b0, 1'b1, 8'd0, 16'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_async: got valid=%b ready=%b cnt=%0d data=%h flags=%b, expected 0 1 0 0000 0000",
               out_valid, in_ready, ovf_cnt, out_data, out_flags);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    base = n_pops;
    out_ready = 1'b1;
    step();
    set_op(16'h0777, 1'b1, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    repeat (5) step();
    n_checks++;
    if (n_pops - base !== 1) begin
      n_fail++;
      $display("FAIL reset_one_output: got %0d outputs, expected 1", n_pops - base);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = 16'h0;
    in_cout   = 1'b0;
    in_ovf    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    clr_cnt   = 1'b0;
    test_reset();
    test_basic_add();
    test_saturation();
    test_subtract();
    test_back_to_back();
    test_counter();
    test_reset_mid_stream();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d undelivered entries, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_result_stage.md
Name: addsub_result_stage

Overview:
- Registered result stage directly downstream of the 16-bit add/subtract unit.
- Captures SUM, C_out and O plus the add/sub control for each operation through a valid/ready handshake.
- Derives NZCV status, optionally saturates on signed overflow, and buffers results in a 2-entry FIFO for the consumer.
- Keeps a sticky, saturating count of overflowed operations for debug/status readout.

Parameters:
- WIDTH, 16: data width; must match the adder width.
- SAT_EN, 1: 1 = replace overflowed results with the saturated value; 0 = pass the raw sum.
- CNT_W, 8: width of the overflow event counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  adder outputs valid this cycle
- in_ready  output  1  stage can accept; equals FIFO not full
- in_sum  input  WIDTH  adder SUM
- in_cout  input  1  adder C_out
- in_ovf  input  1  adder O (signed overflow)
- in_sub  input  1  Add_ctrl of this operation; 1 = subtract
- out_valid  output  1  FIFO head valid; equals FIFO not empty
- out_ready  input  1  consumer accepts the head
- out_data  output  WIDTH  head result (saturated if applicable)
- out_flags  output  4  head flags {N,Z,C,V}
- out_borrow  output  1  head borrow: in_sub & ~in_cout, else 0
- ovf_cnt  output  CNT_W  number of accepted operations with in_ovf=1
- clr_cnt  input  1  synchronous clear of ovf_cnt

Behaviour:
- Reset (rst_n=0, async): FIFO empty, out_valid=0, in_ready=1, out_data=0, out_flags=0, out_borrow=0, ovf_cnt=0.
- Reset asserted mid-operation discards all buffered entries. No output is valid until the first accept after rst_n deasserts.
- Push when in_valid & in_ready. Pop when out_valid & out_ready.
- FIFO: 2 entries, write pointer, read pointer and 2-bit occupancy count. Pointers wrap 1->0.
- Latency: an entry pushed in cycle t is visible at out_* in cycle t+1 if the FIFO was empty. There is no same-cycle bypass.
- Occupancy 2: in_ready=0, input is ignored. A pop that cycle frees a slot; in_ready rises the next cycle (no combinational ready path from out_ready).
- Push and pop in the same cycle at occupancy 1: count stays 1, the new entry follows the popped head.
- out_data, out_flags and out_borrow always reflect the current head entry. They hold stable while out_valid=1 and out_ready=0.
- Saturation (SAT_EN=1, in_ovf=1): result = 0x7FFF if in_sum[15]=1 (positive overflow wrapped negative), else 0x8000. Otherwise result = in_sum.
- Flags are computed at push time and stored with the entry:
  - N = result[15]
  - Z = (result==0)
  - C = in_cout (raw)
  - V = in_ovf (raw, even when saturated)
- ovf_cnt increments on each push with in_ovf=1 and saturates at all-ones (no wrap).
- clr_cnt=1 with no overflow push: ovf_cnt becomes 0.
- clr_cnt=1 together with an overflow push: ovf_cnt becomes 1.
- Inputs sampled while in_valid=0 or in_ready=0 have no effect on any state.

Test Plan:
- Add 0x1234+0x0001 (in_sum=0x1235, cout=0, ovf=0, sub=0), out_ready=1 -> next cycle out_data=0x1235, flags=0000, borrow=0, ovf_cnt=0.
- Add overflow, SAT_EN=1: in_sum=0x8000, ovf=1, cout=0 -> out_data=0x7FFF, flags N=0 Z=0 C=0 V=1, ovf_cnt=1. Same stimulus with SAT_EN=0 -> out_data=0x8000, N=1, V=1.
- Subtract 5-5: in_sum=0x0000, cout=1, sub=1 -> flags Z=1 C=1, borrow=0. Subtract 3-5: in_sum=0xFFFE, cout=0 -> N=1, borrow=1.
- Backpressure: out_ready=0, push 3 ops (A, B, C) -> in_ready drops after 2 pushes and C is not accepted. Out holds A. Raise out_ready -> A then B delivered in order; C accepted one cycle after the first pop.
- Counter: 300 consecutive overflow pushes (CNT_W=8) -> ovf_cnt=255. clr_cnt together with a further overflow push -> ovf_cnt=1.
- Reset mid-stream: two entries buffered, pulse rst_n low asynchronously between clock edges -> out_valid=0, ovf_cnt=0, out_data=0 immediately. After release, one push produces exactly one output.
